// File: rtl/store_narrowing_unit.sv
// Store narrowing unit: places a register value into byte lanes and runs one valid/ready memory write.
// Optional signed-narrowing overflow report enabled by STORE_NARROW_OVERFLOW_CHECK_EN.
module store_narrowing_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] store_data,
    input  logic [31:0] store_address,
    input  logic [1:0]  store_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code,
    output logic        overflow
);

    localparam int unsigned CNT_W = 8;
    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_SIZE     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_mem_valid;
    logic [31:0]      r_mem_address;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_byte_enable;
    logic             r_done;
    logic             r_error;
    logic [1:0]       r_error_code;

    logic             w_size_bad;
    logic             w_misaligned;
    logic [31:0]      w_wdata;
    logic [3:0]       w_byte_enable;

    // Request legality and lane placement, decoded straight from the request inputs
    always_comb begin
        w_size_bad    = (store_size == 2'b11);
        w_misaligned  = ((store_size == SIZE_HALF) && store_address[0]) ||
                        ((store_size == SIZE_WORD) && (store_address[1:0] != 2'b00));
        w_wdata       = store_data;
        w_byte_enable = 4'b1111;
        case (store_size)
            SIZE_BYTE: begin
                w_wdata       = {4{store_data[7:0]}};
                w_byte_enable = 4'(4'b0001 << store_address[1:0]);
            end
            SIZE_HALF: begin
                w_wdata       = {2{store_data[15:0]}};
                w_byte_enable = store_address[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata       = store_data;
                w_byte_enable = 4'b1111;
            end
        endcase
    end

`ifdef STORE_NARROW_OVERFLOW_CHECK_EN
    logic w_overflow;
    logic r_ovf_pending;
    logic r_overflow;

    // Value survives narrowing only if every bit above the new sign bit equals it
    always_comb begin
        case (store_size)
            SIZE_BYTE: w_overflow = !((&store_data[31:7])  || !(|store_data[31:7]));
            SIZE_HALF: w_overflow = !((&store_data[31:15]) || !(|store_data[31:15]));
            default:   w_overflow = 1'b0;
        endcase
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state           <= ST_IDLE;
            r_count           <= '0;
            r_mem_valid       <= 1'b0;
            r_mem_address     <= '0;
            r_mem_wdata       <= '0;
            r_mem_byte_enable <= '0;
            r_done            <= 1'b0;
            r_error           <= 1'b0;
            r_error_code      <= '0;
`ifdef STORE_NARROW_OVERFLOW_CHECK_EN
            r_ovf_pending     <= 1'b0;
            r_overflow        <= 1'b0;
`endif
        end else begin
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_error_code <= '0;
`ifdef STORE_NARROW_OVERFLOW_CHECK_EN
            r_overflow   <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (w_size_bad || w_misaligned) begin
                            r_state      <= ST_RESP;
                            r_error      <= 1'b1;
                            r_error_code <= w_size_bad ? ERR_SIZE : ERR_MISALIGN;
                        end else begin
                            r_state           <= ST_BUSY;
                            r_count           <= '0;
                            r_mem_valid       <= 1'b1;
                            r_mem_address     <= {store_address[31:2], 2'b00};
                            r_mem_wdata       <= w_wdata;
                            r_mem_byte_enable <= w_byte_enable;
`ifdef STORE_NARROW_OVERFLOW_CHECK_EN
                            r_ovf_pending     <= w_overflow;
`endif
                        end
                    end
                end
                ST_BUSY: begin
                    // Ready on the timeout edge still completes the store
                    if (mem_ready || (r_count == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                        r_state           <= ST_RESP;
                        r_mem_valid       <= 1'b0;
                        r_mem_address     <= '0;
                        r_mem_wdata       <= '0;
                        r_mem_byte_enable <= '0;
                        if (mem_ready) begin
                            r_done <= 1'b1;
`ifdef STORE_NARROW_OVERFLOW_CHECK_EN
                            r_overflow <= r_ovf_pending;
`endif
                        end else begin
                            r_error      <= 1'b1;
                            r_error_code <= ERR_TIMEOUT;
                        end
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready       = (r_state == ST_IDLE);
    assign mem_valid       = r_mem_valid;
    assign mem_address     = r_mem_address;
    assign mem_wdata       = r_mem_wdata;
    assign mem_byte_enable = r_mem_byte_enable;
    assign done            = r_done;
    assign error           = r_error;
    assign error_code      = r_error_code;

endmodule

// File: tb/tb_store_narrowing_unit.sv
// Directed self-checking bench for store_narrowing_unit (TIMEOUT_CYCLES = 4).
module tb_store_narrowing_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] store_data;
    logic [31:0] store_address;
    logic [1:0]  store_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        done;
    logic        error;
    logic [1:0]  error_code;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

`ifdef STORE_NARROW_OVERFLOW_CHECK_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    store_narrowing_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .store_data     (store_data),
        .store_address  (store_address),
        .store_size     (store_size),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .done           (done),
        .error          (error),
        .error_code     (error_code),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; request is accepted on the next posedge (T), returns at negedge of T+1
    task automatic send(input logic [31:0] d, input logic [31:0] a, input logic [1:0] s);
        store_data    = d;
        store_address = a;
        store_size    = s;
        req_valid     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_valid"}, 32'(mem_valid), 32'h0);
        chk({tag, "_done"},      32'(done),      32'h0);
        chk({tag, "_error"},     32'(error),     32'h0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h1);
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; mem_ready = 1'b0;
        store_data = '0; store_address = '0; store_size = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // reset state
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_wdata",   mem_wdata,   32'h0);
        chk("rst_be",          32'(mem_byte_enable), 32'h0);
        chk("rst_code",        32'(error_code), 32'h0);
        chk("rst_overflow",    32'(overflow),   32'h0);
        chk_idle_outputs("rst");

        // byte store, ready tied high
        mem_ready = 1'b1;
        send(32'h0000_00A5, 32'h1000_0003, 2'b00);
        chk("b_mem_valid", 32'(mem_valid), 32'h1);
        chk("b_addr",      mem_address, 32'h1000_0000);
        chk("b_wdata",     mem_wdata,   32'hA5A5_A5A5);
        chk("b_be",        32'(mem_byte_enable), 32'h8);
        chk("b_req_ready", 32'(req_ready), 32'h0);
        chk("b_done_early", 32'(done), 32'h0);
        @(negedge clock);
        chk("b_done",      32'(done), 32'h1);
        chk("b_error",     32'(error), 32'h0);
        chk("b_code",      32'(error_code), 32'h0);
        chk("b_mv_low",    32'(mem_valid), 32'h0);
        chk("b_be_low",    32'(mem_byte_enable), 32'h0);
        @(negedge clock);
        chk_idle_outputs("b_after");

        // halfword store, ready delayed three cycles
        mem_ready = 1'b0;
        send(32'hFFFF_8001, 32'h2000_0002, 2'b01);
        for (int i = 0; i < 4; i++) begin
            chk("h_mem_valid", 32'(mem_valid), 32'h1);
            chk("h_addr",      mem_address, 32'h2000_0000);
            chk("h_wdata",     mem_wdata,   32'h8001_8001);
            chk("h_be",        32'(mem_byte_enable), 32'hC);
            chk("h_done_early", 32'(done), 32'h0);
            if (i == 3) mem_ready = 1'b1;
            @(negedge clock);
        end
        mem_ready = 1'b0;
        chk("h_done",     32'(done), 32'h1);
        chk("h_overflow", 32'(overflow), 32'h0);
        chk("h_error",    32'(error), 32'h0);
        @(negedge clock);
        chk_idle_outputs("h_after");

        // misaligned word
        send(32'h1234_5678, 32'h0000_0006, 2'b10);
        chk("w_mis_error",     32'(error), 32'h1);
        chk("w_mis_code",      32'(error_code), 32'h1);
        chk("w_mis_mem_valid", 32'(mem_valid), 32'h0);
        chk("w_mis_done",      32'(done), 32'h0);
        chk("w_mis_req_ready", 32'(req_ready), 32'h0);
        @(negedge clock);
        chk_idle_outputs("w_mis_after");

        // reserved size at aligned address
        send(32'h1234_5678, 32'h0000_0010, 2'b11);
        chk("sz_error",     32'(error), 32'h1);
        chk("sz_code",      32'(error_code), 32'h2);
        chk("sz_mem_valid", 32'(mem_valid), 32'h0);
        @(negedge clock);
        chk_idle_outputs("sz_after");

        // reserved size at misaligned address: size error wins
        send(32'h0, 32'h0000_0003, 2'b11);
        chk("szmis_code", 32'(error_code), 32'h2);
        @(negedge clock);

        // misaligned halfword
        send(32'h0, 32'h0000_0001, 2'b01);
        chk("h_mis_error", 32'(error), 32'h1);
        chk("h_mis_code",  32'(error_code), 32'h1);
        @(negedge clock);

        // timeout with ready held low
        send(32'h0000_0012, 32'h0000_0004, 2'b00);
        for (int i = 0; i < 4; i++) begin
            chk("to_mem_valid", 32'(mem_valid), 32'h1);
            chk("to_be",        32'(mem_byte_enable), 32'h1);
            @(negedge clock);
        end
        chk("to_mv_low", 32'(mem_valid), 32'h0);
        chk("to_error",  32'(error), 32'h1);
        chk("to_code",   32'(error_code), 32'h3);
        chk("to_done",   32'(done), 32'h0);
        @(negedge clock);
        chk_idle_outputs("to_after");

        // ready arrives on the timeout edge: store completes
        send(32'h0000_0034, 32'h0000_0005, 2'b00);
        for (int i = 0; i < 4; i++) begin
            chk("tr_mem_valid", 32'(mem_valid), 32'h1);
            chk("tr_be",        32'(mem_byte_enable), 32'h2);
            if (i == 3) mem_ready = 1'b1;
            @(negedge clock);
        end
        mem_ready = 1'b0;
        chk("tr_done",  32'(done), 32'h1);
        chk("tr_error", 32'(error), 32'h0);
        chk("tr_code",  32'(error_code), 32'h0);
        @(negedge clock);
        chk_idle_outputs("tr_after");

        // reset during the second BUSY cycle
        send(32'h0000_5555, 32'h0000_0008, 2'b01);
        chk("rb_mem_valid", 32'(mem_valid), 32'h1);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk_idle_outputs("rb");
        chk("rb_wdata", mem_wdata, 32'h0);
        @(negedge clock);
        chk_idle_outputs("rb_later");

        // normal word store after reset
        mem_ready = 1'b1;
        send(32'hDEAD_BEEF, 32'h0000_0008, 2'b10);
        chk("wd_mem_valid", 32'(mem_valid), 32'h1);
        chk("wd_addr",      mem_address, 32'h0000_0008);
        chk("wd_wdata",     mem_wdata, 32'hDEAD_BEEF);
        chk("wd_be",        32'(mem_byte_enable), 32'hF);
        @(negedge clock);
        chk("wd_done",     32'(done), 32'h1);
        chk("wd_overflow", 32'(overflow), 32'h0);
        @(negedge clock);

        // overflow on positive byte that loses its sign
        send(32'h0000_0080, 32'h0000_0001, 2'b00);
        chk("ov1_wdata", mem_wdata, 32'h8080_8080);
        chk("ov1_be",    32'(mem_byte_enable), 32'h2);
        @(negedge clock);
        chk("ov1_done",     32'(done), 32'h1);
        chk("ov1_overflow", 32'(overflow), 32'(OVF_EN));
        @(negedge clock);

        // properly sign-extended negative byte
        send(32'hFFFF_FF80, 32'h0000_0002, 2'b00);
        chk("ov2_wdata", mem_wdata, 32'h8080_8080);
        chk("ov2_be",    32'(mem_byte_enable), 32'h4);
        @(negedge clock);
        chk("ov2_done",     32'(done), 32'h1);
        chk("ov2_overflow", 32'(overflow), 32'h0);
        @(negedge clock);

        // halfword that does not fit in 16 signed bits
        send(32'h0001_0000, 32'h0000_0000, 2'b01);
        chk("ov3_wdata", mem_wdata, 32'h0000_0000);
        chk("ov3_be",    32'(mem_byte_enable), 32'h3);
        @(negedge clock);
        chk("ov3_done",     32'(done), 32'h1);
        chk("ov3_overflow", 32'(overflow), 32'(OVF_EN));
        @(negedge clock);
        chk_idle_outputs("end");
        mem_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_narrowing_unit.md
# store_narrowing_unit

Store-path counterpart of the 16→32 sign-extension unit in the 32-bit MIPS CPU. It takes a 32-bit register value, a target address and an access size (byte/halfword/word) from the execute stage, narrows the value into the correct byte lanes with matching byte enables, and runs a valid/ready write transaction to data memory. It reports completion, alignment, size and timeout errors. With the optional overflow check compiled in, it also flags stores whose value does not survive signed narrowing.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: number of consecutive BUSY cycles without `mem_ready` before the transaction aborts; legal range 1..255.

Ports:
- clock  in  1  single clock; all logic on the rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request; equals 1 only in IDLE
- store_data  in  32  register value to store
- store_address  in  32  byte address
- store_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- mem_valid  out  1  write request to memory
- mem_ready  in  1  memory accepts the write
- mem_address  out  32  word-aligned address, {store_address[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated write data
- mem_byte_enable  out  4  active lanes; bit i enables mem_wdata[8i+7:8i]
- done  out  1  one-cycle pulse: store completed
- error  out  1  one-cycle pulse: store aborted
- error_code  out  2  00 none, 01 misaligned, 10 invalid size, 11 timeout; valid while done or error is high
- overflow  out  1  value did not fit the signed narrowed width; valid while done is high

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: `req_ready`=1. A request is accepted when `req_valid`=1 and `req_ready`=1.
  - If the request is legal, capture the lane data and go to BUSY.
  - If it is illegal, go to RESP with `error` set. No memory request is issued.
- Illegal requests:
  - `store_size`=11 gives code 10. This takes priority over the misalignment check.
  - Halfword with `store_address[0]`=1 gives code 01.
  - Word with `store_address[1:0]`≠00 gives code 01.
- Lane placement, with a = `store_address[1:0]`:
  - Byte: wdata = {4{data[7:0]}}, byte_enable = 4'b0001 << a.
  - Halfword: wdata = {2{data[15:0]}}, byte_enable = a[1] ? 4'b1100 : 4'b0011.
  - Word: wdata = data, byte_enable = 4'b1111.
- BUSY:
  - `mem_valid`=1. `mem_address`, `mem_wdata` and `mem_byte_enable` stay constant throughout BUSY.
  - On an edge with `mem_ready`=1, go to RESP with `done` set.
  - A timeout counter clears on entry to BUSY and increments each BUSY cycle with `mem_ready`=0.
  - On the edge where the counter would reach TIMEOUT_CYCLES, go to RESP with error code 11 and deassert `mem_valid`.
  - `mem_ready` on the same edge as the timeout wins: the store completes with `done`.
- RESP:
  - Exactly one cycle.
  - Exactly one of `done` or `error` is high, and `error_code` and `overflow` are presented with it.
  - Then return to IDLE.
- Memory-side outputs return to 0 whenever `mem_valid`=0.
- `mem_ready` while `mem_valid`=0 is ignored.
- Request inputs are ignored outside IDLE.

## Timing
- All outputs are registered except `req_ready`, which is decoded from the state.
- Reset: when `reset_n`=0 at a rising edge, the state goes to IDLE and the counter clears. After that edge:
  - `mem_valid`, `mem_address`, `mem_wdata`, `mem_byte_enable`, `done`, `error`, `error_code` and `overflow` are all 0.
  - `req_ready`=1.
- Reset in BUSY drops the transaction; `mem_valid` is low after that edge and no `done`/`error` is produced.
- Legal store accepted at edge T:
  - `mem_valid` is high from T+1.
  - If `mem_ready` is high during cycle T+1, `done` is high in T+2 and `req_ready` is high in T+3.
  - Minimum issue interval is 3 cycles.
- Illegal store accepted at T: `error` is high in T+1 and `req_ready` is high in T+2.
- Timeout: with `mem_ready` held 0, `mem_valid` is high for exactly TIMEOUT_CYCLES cycles, then `error` pulses with code 11.

## Configuration
- Macro: STORE_NARROW_OVERFLOW_CHECK_EN.
- Defined:
  - `overflow` is computed at acceptance and reported with `done`.
  - Byte: `overflow` = 1 if `store_data[31:7]` is not all-equal.
  - Halfword: `overflow` = 1 if `store_data[31:15]` is not all-equal.
  - Word: `overflow` = 0.
  - Overflow never blocks or alters the store.
- Undefined: `overflow` is tied to 0 and no comparison logic is built.

## Test plan
- Byte store, data 32'h0000_00A5, address 32'h1000_0003, `mem_ready` tied 1 → `mem_valid` at T+1 with `mem_address` 32'h1000_0000, wdata 32'hA5A5_A5A5, byte_enable 4'b1000; `done` at T+2.
- Halfword store, data 32'hFFFF_8001, address 32'h2000_0002, `mem_ready` delayed 3 cycles → byte_enable 4'b1100, wdata 32'h8001_8001 held stable for 4 cycles; `done` with `overflow`=0.
- Word store at address 32'h0000_0006 → no `mem_valid`; `error` at T+1, code 01. Then `store_size`=11 at an aligned address → code 10.
- TIMEOUT_CYCLES=4, `mem_ready`=0 → `mem_valid` high exactly 4 cycles, then `error` code 11 and `req_ready` again. Repeat with `mem_ready` rising on the 4th cycle → `done`.
- `reset_n`=0 on the 2nd BUSY cycle → `mem_valid`=0 next cycle, no `done`/`error`, `req_ready`=1. A following legal store completes normally.
- With the macro defined: byte store of 32'h0000_0080 → `overflow`=1 and the store still completes; 32'hFFFF_FF80 → `overflow`=0. With the macro undefined, `overflow` stays 0 for both.
